sample_decimator: RTL and testbench
===================================

Name: sample_decimator

Overview:
- Upstream stage of the waveform display path. Sits between the codec sample source and the wave display top level.
- Takes a strobed stream of signed audio samples and groups them into blocks of 1, 2, 4 or 8 samples.
- Emits one averaged sample per block with a one-cycle strobe. This widens the visible time span on the 256-column waveform.
- Outputs drive the display's new_sample / sample inputs directly.

Parameters:
- WIDTH, 18, sample width in bits, two's complement.
- MAX_LOG2, 3, log2 of the largest block size; sets accumulator width to WIDTH+MAX_LOG2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- new_sample_in  input  1  one-cycle strobe; sample_in is valid this cycle; may assert on consecutive cycles
- sample_in  input  WIDTH  signed input sample
- decim_sel  input  2  block size = 2^decim_sel (0 = pass-through, 3 = 8)
- freeze  input  1  level; suspends output while high
- new_sample_out  output  1  one-cycle strobe, one per completed block
- sample_out  output  WIDTH  signed block result; holds its value between strobes
- busy  output  1  high while a partial block is held (cnt != 0)

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high; all state changes on the rising edge of clk.
- Reset values:
  - new_sample_out=0, sample_out=0, busy=0.
  - acc=0, cnt=0, k_lat=0, state=RUN.
- Internal state:
  - acc: signed, WIDTH+MAX_LOG2 bits.
  - cnt: MAX_LOG2 bits.
  - k_lat: latched decim_sel for the current block.
- States:
  - RUN: accumulating.
  - FROZEN: freeze high.
- Transitions:
  - RUN->FROZEN when freeze=1.
  - FROZEN->RUN when freeze=0.
  - Entering FROZEN clears acc and cnt; the partial block is discarded and no strobe is produced.
  - Strobes arriving while FROZEN are ignored.
- Block start (cnt==0 on an accepted strobe): k_lat <= decim_sel. A decim_sel change mid-block takes effect at the next block.
- Accepted strobe in RUN:
  - If cnt == 2^k_lat - 1 (the last sample of the block; when cnt==0 use the current decim_sel):
    - sample_out <= (acc + sext(sample_in)) >>> k_lat, arithmetic shift (floor), truncated to WIDTH.
    - new_sample_out <= 1.
    - acc <= 0, cnt <= 0.
  - Otherwise: acc <= acc + sext(sample_in), cnt <= cnt+1.
- Latency: new_sample_out asserts exactly one cycle after the strobe carrying the block's last sample. sample_out updates on the same edge.
- new_sample_out is high for one cycle only and defaults to 0 every other cycle.
- Back-to-back input strobes are all accepted; with decim_sel=0, output strobes are also back-to-back.
- Overflow is impossible: 8 × 18-bit values fit in 21 bits.
- Reset mid-block: partial block discarded, no strobe.
- Reset and freeze together: reset wins; state=RUN after reset if freeze=0, otherwise FROZEN on the next edge.

Optional Feature:
- Macro: SAMPLE_DECIMATOR_PEAK_EN.
- Defined:
  - Adds input port peak_mode (1 bit), latched at block start like decim_sel.
  - When peak_mode=1, the block output is the input sample with the largest magnitude (first occurrence wins on ties) instead of the average.
  - Tracking register is reset to the first sample of each block.
  - Latency and strobe timing are identical to average mode.
- Undefined: port absent; average mode only.

Decomposition:
- Shared package waveform_pkg:
  - SAMPLE_W=18.
  - DECIM_MAX_LOG2=3.
  - enum decim_state_t {RUN, FROZEN}.
- Sub-module: none required.
  - With SAMPLE_DECIMATOR_PEAK_EN, a small comparator sub-module abs_max_sel (combinational |a|>|b| select) is natural.

Test Plan:
- Pass-through: decim_sel=0; strobes with 100, -5, 7 on consecutive cycles -> new_sample_out high on the 3 following cycles, sample_out 100, -5, 7.
- Average of 4: decim_sel=2; samples 10, 20, 30, 41 spaced 5 cycles apart -> single strobe 1 cycle after 41, sample_out=25; no strobe earlier.
- Negative floor: decim_sel=1; samples -3, 0 -> sample_out=-2 (arithmetic floor of -1.5); 18-bit extremes -131072 ×8 with decim_sel=3 -> -131072, no overflow.
- Mid-block select change: decim_sel=1, first sample 4, then decim_sel=3, second sample 8 -> output 6 after 2 samples; the next block uses 8 samples.
- Freeze/reset mid-block: decim_sel=2, 2 samples, then freeze 3 cycles during which strobes arrive -> no output; after release, 4 samples of 12 -> one strobe, 12. Repeat with reset instead of freeze -> same; outputs 0 after reset.
- Peak (macro defined): peak_mode=1, decim_sel=2, samples 5, -9, 9, 3 -> sample_out=-9.

Source files
------------

// File: rtl/waveform_pkg.sv
// Shared types and sizing for the waveform display path.
// Sample width and largest decimation block size used by the decimator front end.
package waveform_pkg;

    localparam int SAMPLE_W       = 18;
    localparam int DECIM_MAX_LOG2 = 3;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } decim_state_t;

endpackage

// File: rtl/sample_decimator_if.sv
// Sample stream in / block result out for sample_decimator; peak_mode exists only
// when SAMPLE_DECIMATOR_PEAK_EN is defined. Strobed, no backpressure.
interface sample_decimator_if
    import waveform_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
);
`ifdef SAMPLE_DECIMATOR_PEAK_EN
    logic                    peak_mode;
`endif
    logic                    new_sample_in;
    logic signed [WIDTH-1:0] sample_in;
    logic [1:0]              decim_sel;
    logic                    freeze;
    logic                    new_sample_out;
    logic signed [WIDTH-1:0] sample_out;
    logic                    busy;

    modport master (
`ifdef SAMPLE_DECIMATOR_PEAK_EN
        output peak_mode,
`endif
        output new_sample_in, sample_in, decim_sel, freeze,
        input  new_sample_out, sample_out, busy
    );

    modport slave (
`ifdef SAMPLE_DECIMATOR_PEAK_EN
        input  peak_mode,
`endif
        input  new_sample_in, sample_in, decim_sel, freeze,
        output new_sample_out, sample_out, busy
    );
endinterface

// File: rtl/sample_decimator.sv
// Averages blocks of 2^decim_sel strobed samples (peak-magnitude option: SAMPLE_DECIMATOR_PEAK_EN).
// Result strobes one cycle after a block's last sample; no backpressure, freeze discards the partial block.
module sample_decimator
    import waveform_pkg::*;
#(
    parameter int WIDTH    = SAMPLE_W,
    parameter int MAX_LOG2 = DECIM_MAX_LOG2
)
(
    input  logic              clk,
    input  logic              reset,
    sample_decimator_if.slave bus
);

    localparam int         ACC_W     = WIDTH + MAX_LOG2;
    localparam logic [0:0] ST_RUN    = RUN;
    localparam logic [0:0] ST_FROZEN = FROZEN;

    logic [0:0]              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [MAX_LOG2-1:0]     r_cnt;
    logic [1:0]              r_k_lat;
    logic                    r_new_sample_out;
    logic signed [WIDTH-1:0] r_sample_out;

    logic                    w_accept;
    logic                    w_block_start;
    logic [1:0]              w_k;
    logic [MAX_LOG2-1:0]     w_last_cnt;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [WIDTH-1:0] w_avg;
    logic signed [WIDTH-1:0] w_result;

    assign w_accept      = bus.new_sample_in && (r_state == ST_RUN) && !bus.freeze;
    assign w_block_start = (r_cnt == '0);
    // The first sample of a block must see the new block size, not the stale latch.
    assign w_k           = w_block_start ? bus.decim_sel : r_k_lat;
    assign w_last_cnt    = MAX_LOG2'((32'd1 << w_k) - 32'd1);
    assign w_last        = (r_cnt == w_last_cnt);
    assign w_sum         = r_acc + ACC_W'(bus.sample_in);
    assign w_avg         = WIDTH'(w_sum >>> w_k);

`ifdef SAMPLE_DECIMATOR_PEAK_EN
    function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH:0] e;
        e   = {v[WIDTH-1], v};
        mag = (e < 0) ? -e : e;
    endfunction

    logic                    r_peak_lat;
    logic signed [WIDTH-1:0] r_peak;
    logic                    w_peak_mode;
    logic signed [WIDTH-1:0] w_peak_next;

    assign w_peak_mode = w_block_start ? bus.peak_mode : r_peak_lat;
    // Strict greater-than keeps the earliest sample on magnitude ties.
    assign w_peak_next = (w_block_start || (mag(bus.sample_in) > mag(r_peak))) ? bus.sample_in : r_peak;
    assign w_result    = w_peak_mode ? w_peak_next : w_avg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak_lat <= 1'b0;
            r_peak     <= '0;
        end else if (w_accept) begin
            if (w_block_start) r_peak_lat <= bus.peak_mode;
            r_peak <= w_peak_next;
        end
    end
`else
    assign w_result = w_avg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_acc            <= '0;
            r_cnt            <= '0;
            r_k_lat          <= '0;
            r_new_sample_out <= 1'b0;
            r_sample_out     <= '0;
        end else begin
            r_new_sample_out <= 1'b0;
            if (r_state == ST_RUN) begin
                if (bus.freeze) begin
                    r_state <= ST_FROZEN;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else if (w_accept) begin
                    if (w_block_start) r_k_lat <= bus.decim_sel;
                    if (w_last) begin
                        r_sample_out     <= w_result;
                        r_new_sample_out <= 1'b1;
                        r_acc            <= '0;
                        r_cnt            <= '0;
                    end else begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + MAX_LOG2'(1);
                    end
                end
            end else if (!bus.freeze) begin
                r_state <= ST_RUN;
            end
        end
    end

    assign bus.new_sample_out = r_new_sample_out;
    assign bus.sample_out     = r_sample_out;
    assign bus.busy           = (r_cnt != '0);

endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator: pass-through, averaging, floor, extremes, select change, freeze/reset.
module tb_sample_decimator;
    import waveform_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sample_decimator_if #(.WIDTH(SAMPLE_W)) bus();

    sample_decimator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    int s0;

    always @(negedge clk) if (bus.new_sample_out === 1'b1) strobes++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input int gap);
        bus.new_sample_in = 1'b1;
        bus.sample_in     = SAMPLE_W'(v);
        tick();
        bus.new_sample_in = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic int dat();
        return int'(bus.sample_out);
    endfunction

    initial begin
        reset             = 1'b1;
        bus.new_sample_in = 1'b0;
        bus.sample_in     = '0;
        bus.decim_sel     = 2'd0;
        bus.freeze        = 1'b0;
`ifdef SAMPLE_DECIMATOR_PEAK_EN
        bus.peak_mode     = 1'b0;
`endif
        repeat (2) tick();
        check("rst_vld",  int'(bus.new_sample_out), 0);
        check("rst_dat",  dat(), 0);
        check("rst_busy", int'(bus.busy), 0);
        reset = 1'b0;
        tick();

        // pass-through, back-to-back
        bus.decim_sel = 2'd0;
        s0 = strobes;
        send(100, 0); check("pt_vld0", int'(bus.new_sample_out), 1); check("pt_dat0", dat(), 100);
        send(-5, 0);  check("pt_vld1", int'(bus.new_sample_out), 1); check("pt_dat1", dat(), -5);
        send(7, 0);   check("pt_vld2", int'(bus.new_sample_out), 1); check("pt_dat2", dat(), 7);
        tick();
        check("pt_idle",  int'(bus.new_sample_out), 0);
        check("pt_hold",  dat(), 7);
        check("pt_count", strobes - s0, 3);

        // average of 4, spaced samples
        bus.decim_sel = 2'd2;
        s0 = strobes;
        send(10, 4); send(20, 4); send(30, 4);
        check("avg_early", strobes - s0, 0);
        check("avg_busy",  int'(bus.busy), 1);
        send(41, 0);
        check("avg_vld", int'(bus.new_sample_out), 1);
        check("avg_dat", dat(), 25);
        tick();
        check("avg_once",  int'(bus.new_sample_out), 0);
        check("avg_busy0", int'(bus.busy), 0);

        // negative floor
        bus.decim_sel = 2'd1;
        send(-3, 2); send(0, 0);
        check("floor_dat", dat(), -2);
        tick();

        // full-scale negative, block of 8
        bus.decim_sel = 2'd3;
        repeat (7) send(-131072, 0);
        check("ext_early", int'(bus.new_sample_out), 0);
        send(-131072, 0);
        check("ext_vld", int'(bus.new_sample_out), 1);
        check("ext_dat", dat(), -131072);
        tick();

        // select change mid-block takes effect on the next block
        bus.decim_sel = 2'd1;
        send(4, 1);
        bus.decim_sel = 2'd3;
        send(8, 0);
        check("msel_vld", int'(bus.new_sample_out), 1);
        check("msel_dat", dat(), 6);
        tick();
        s0 = strobes;
        for (int i = 1; i <= 7; i++) send(i, 0);
        check("msel_wait", strobes - s0, 0);
        check("msel_wait_vld", int'(bus.new_sample_out), 0);
        send(8, 0);
        check("msel8_vld", int'(bus.new_sample_out), 1);
        check("msel8_dat", dat(), 4);
        tick();

        // freeze mid-block
        bus.decim_sel = 2'd2;
        send(5, 0); send(5, 0);
        check("frz_busy", int'(bus.busy), 1);
        s0 = strobes;
        bus.freeze        = 1'b1;
        bus.new_sample_in = 1'b1;
        bus.sample_in     = SAMPLE_W'(99);
        repeat (3) tick();
        check("frz_busy0", int'(bus.busy), 0);
        bus.new_sample_in = 1'b0;
        bus.freeze        = 1'b0;
        tick();
        repeat (3) send(12, 0);
        check("frz_nostrobe", strobes - s0, 0);
        send(12, 0);
        check("frz_vld", int'(bus.new_sample_out), 1);
        check("frz_dat", dat(), 12);
        tick();
        check("frz_count", strobes - s0, 1);

        // reset mid-block
        send(5, 0); send(5, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_vld",  int'(bus.new_sample_out), 0);
        check("rst2_dat",  dat(), 0);
        check("rst2_busy", int'(bus.busy), 0);
        s0 = strobes;
        repeat (3) send(12, 0);
        send(12, 0);
        check("rst2_dat12", dat(), 12);
        tick();
        check("rst2_count", strobes - s0, 1);

`ifdef SAMPLE_DECIMATOR_PEAK_EN
        bus.peak_mode = 1'b1;
        bus.decim_sel = 2'd2;
        send(5, 0); send(-9, 0); send(9, 0); send(3, 0);
        check("peak_dat", dat(), -9);
        bus.peak_mode = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
